// File: rtl/leg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : leg_pkg                                                      |
// | Desc   : Shared constants and state encoding for the LEG fetch stage. |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
package leg_pkg;

    localparam logic [7:0] NOP_OPCODE  = 8'hC0;
    localparam logic [7:0] NOP_DEST    = 8'h06;
    localparam logic [7:0] HALT_OPCODE = 8'hFF;
    localparam int         PC_STEP     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic logic is_halt(input logic [7:0] op);
        return op == HALT_OPCODE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/leg_prog_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : leg_prog_rom                                                 |
// | Desc   : 256x8 program store, byte write, 4-byte async read at addr.  |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module leg_prog_rom #(
    parameter string INIT_FILE = ""
) (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_b0,
    output logic [7:0] rd_b1,
    output logic [7:0] rd_b2,
    output logic [7:0] rd_b3
);

    logic [7:0] r_mem [256];
    logic [7:0] w_a1;
    logic [7:0] w_a2;
    logic [7:0] w_a3;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Byte addresses wrap at 256 so an instruction at 0xFD..0xFF reads across 0x00.
    assign w_a1  = rd_addr + 8'd1;
    assign w_a2  = rd_addr + 8'd2;
    assign w_a3  = rd_addr + 8'd3;

    assign rd_b0 = r_mem[rd_addr];
    assign rd_b1 = r_mem[w_a1];
    assign rd_b2 = r_mem[w_a2];
    assign rd_b3 = r_mem[w_a3];

endmodule
`default_nettype wire

// File: rtl/leg_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : leg_fetch                                                    |
// | Desc   : LEG CPU fetch/issue stage: program store, pc and run control.|
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module leg_fetch
    import leg_pkg::*;
#(
    parameter string INIT_FILE = "",
    parameter int    PC_STEP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        prog_we,
    input  logic [7:0]  prog_addr,
    input  logic [7:0]  prog_data,
    input  logic        skip,
    input  logic [7:0]  skip_data,
    input  logic [23:0] delay_reg,
    output logic [7:0]  pc,
    output logic [7:0]  opcode,
    output logic        imm_a,
    output logic        imm_b,
    output logic [7:0]  data_a,
    output logic [7:0]  data_b,
    output logic [7:0]  data_in,
    output logic        running,
    output logic        halted
);

    localparam logic [7:0] c_step = 8'(PC_STEP);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pc;
    logic [7:0] w_pc_nxt;
    logic       w_issue;
    logic       w_mem_we;
    logic [7:0] w_op;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic [7:0] w_dst;

    assign w_mem_we = prog_we && (r_state != ST_RUN);

    leg_prog_rom #(
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk     (clk),
        .we      (w_mem_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (r_pc),
        .rd_b0   (w_op),
        .rd_b1   (w_a),
        .rd_b2   (w_b),
        .rd_b3   (w_dst)
    );

    assign w_issue = (r_state == ST_RUN) && (delay_reg == 24'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Halt outranks a jump; a stalled cycle neither advances nor jumps.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        unique case (r_state)
            ST_IDLE, ST_HALT: begin
                if (run) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = 8'd0;
                end
            end
            ST_RUN: begin
                if (w_issue) begin
                    if (is_halt(w_op)) begin
                        w_state_nxt = ST_HALT;
                    end else if (skip) begin
                        w_pc_nxt = skip_data;
                    end else begin
                        w_pc_nxt = r_pc + c_step;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = 8'd0;
            end
        endcase
    end

    assign pc      = r_pc;
    assign opcode  = w_issue ? w_op  : NOP_OPCODE;
    assign data_a  = w_issue ? w_a   : 8'd0;
    assign data_b  = w_issue ? w_b   : 8'd0;
    assign data_in = w_issue ? w_dst : NOP_DEST;
    assign imm_a   = opcode[7];
    assign imm_b   = opcode[6];
    assign running = (r_state == ST_RUN);
    assign halted  = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_leg_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_leg_fetch                                                 |
// | Desc   : Directed scoreboard bench for the LEG fetch/issue stage.     |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module tb_leg_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [7:0]  prog_data;
    logic        skip;
    logic [7:0]  skip_data;
    logic [23:0] delay_reg;
    logic [7:0]  pc;
    logic [7:0]  opcode;
    logic        imm_a;
    logic        imm_b;
    logic [7:0]  data_a;
    logic [7:0]  data_b;
    logic [7:0]  data_in;
    logic        running;
    logic        halted;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] din;
        logic       run;
        logic       hlt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    leg_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .skip      (skip),
        .skip_data (skip_data),
        .delay_reg (delay_reg),
        .pc        (pc),
        .opcode    (opcode),
        .imm_a     (imm_a),
        .imm_b     (imm_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .data_in   (data_in),
        .running   (running),
        .halted    (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] d, input logic r, input logic h);
        sb.push_back('{pc: p, op: op, a: a, b: b, din: d, run: r, hlt: h});
    endtask

    task automatic check(input string tag);
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            cmp(tag, "pc",      pc,             e.pc);
            cmp(tag, "opcode",  opcode,         e.op);
            cmp(tag, "imm_a",   {7'd0, imm_a},  {7'd0, e.op[7]});
            cmp(tag, "imm_b",   {7'd0, imm_b},  {7'd0, e.op[6]});
            cmp(tag, "data_a",  data_a,         e.a);
            cmp(tag, "data_b",  data_b,         e.b);
            cmp(tag, "data_in", data_in,        e.din);
            cmp(tag, "running", {7'd0, running}, {7'd0, e.run});
            cmp(tag, "halted",  {7'd0, halted},  {7'd0, e.hlt});
        end
    endtask

    task automatic load(input logic [7:0] addr, input logic [31:0] word);
        for (int k = 0; k < 4; k++) begin
            prog_we   = 1'b1;
            prog_addr = addr + 8'(k);
            prog_data = word[31 - 8*k -: 8];
            tick();
        end
        prog_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = 8'd0; prog_data = 8'd0;
        skip = 1'b0; skip_data = 8'd0; delay_reg = 24'd0;
        tick(); tick();
        rst = 1'b0;
        push(8'h00, 8'hC0, 8'h00, 8'h00, 8'h06, 1'b0, 1'b0); check("reset");

        load(8'h00, 32'h04050600);
        load(8'h04, 32'h04010101);
        push(8'h00, 8'hC0, 8'h00, 8'h00, 8'h06, 1'b0, 1'b0); check("idle_load");
        load(8'h08, 32'h10000000);
        load(8'h0C, 32'h12000000);
        load(8'h10, 32'h20010203);
        load(8'h14, 32'h21040506);
        load(8'h18, 32'h22070809);
        load(8'h20, 32'h11223344);
        load(8'h30, 32'h99010203);
        load(8'h40, 32'h77000000);
        load(8'hFC, 32'h810A0B0C);

        run = 1'b1; tick(); run = 1'b0;
        push(8'h00, 8'h04, 8'h05, 8'h06, 8'h00, 1'b1, 1'b0); check("run_pc00");
        tick();
        push(8'h04, 8'h04, 8'h01, 8'h01, 8'h01, 1'b1, 1'b0); check("run_pc04");
        tick();
        push(8'h08, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0); check("run_pc08");
        skip = 1'b1; skip_data = 8'h20; tick(); skip = 1'b0;
        prog_we = 1'b1; prog_addr = 8'h40; prog_data = 8'hAA;
        push(8'h20, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0); check("jump_20");
        skip = 1'b1; skip_data = 8'hFC; tick(); skip = 1'b0; prog_we = 1'b0;
        push(8'hFC, 8'h81, 8'h0A, 8'h0B, 8'h0C, 1'b1, 1'b0); check("jump_FC");
        tick();
        push(8'h00, 8'h04, 8'h05, 8'h06, 8'h00, 1'b1, 1'b0); check("wrap_00");
        skip = 1'b1; skip_data = 8'h10; tick(); skip = 1'b0;
        push(8'h10, 8'h20, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0); check("jump_10");

        tick();
        delay_reg = 24'd3; skip = 1'b1; skip_data = 8'h80;
        push(8'h14, 8'hC0, 8'h00, 8'h00, 8'h06, 1'b1, 1'b0); check("stall_1");
        tick(); delay_reg = 24'd2;
        push(8'h14, 8'hC0, 8'h00, 8'h00, 8'h06, 1'b1, 1'b0); check("stall_2");
        tick(); delay_reg = 24'd1;
        push(8'h14, 8'hC0, 8'h00, 8'h00, 8'h06, 1'b1, 1'b0); check("stall_3");
        tick(); delay_reg = 24'd0; skip = 1'b0;
        push(8'h14, 8'h21, 8'h04, 8'h05, 8'h06, 1'b1, 1'b0); check("stall_resume");
        tick();
        push(8'h18, 8'h22, 8'h07, 8'h08, 8'h09, 1'b1, 1'b0); check("run_pc18");

        rst = 1'b1; tick(); rst = 1'b0;
        push(8'h00, 8'hC0, 8'h00, 8'h00, 8'h06, 1'b0, 1'b0); check("rst_midrun");

        prog_we = 1'b1; prog_addr = 8'h0C; prog_data = 8'hFF; run = 1'b1;
        tick(); prog_we = 1'b0; run = 1'b0;
        push(8'h00, 8'h04, 8'h05, 8'h06, 8'h00, 1'b1, 1'b0); check("we_with_run");
        skip = 1'b1; skip_data = 8'h0C; tick(); skip_data = 8'h20;
        push(8'h0C, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0); check("halt_issue");
        tick(); skip = 1'b0;
        push(8'h0C, 8'hC0, 8'h00, 8'h00, 8'h06, 1'b0, 1'b1); check("halted");
        prog_we = 1'b1; prog_addr = 8'h30; prog_data = 8'h55; tick(); prog_we = 1'b0;
        push(8'h0C, 8'hC0, 8'h00, 8'h00, 8'h06, 1'b0, 1'b1); check("halt_hold");
        run = 1'b1; tick(); run = 1'b0;
        push(8'h00, 8'h04, 8'h05, 8'h06, 8'h00, 1'b1, 1'b0); check("restart");

        skip = 1'b1; skip_data = 8'h40; tick();
        push(8'h40, 8'h77, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0); check("run_we_ignored");
        skip_data = 8'h30; tick();
        push(8'h30, 8'h55, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0); check("halt_we_landed");
        skip_data = 8'hFE; tick(); skip = 1'b0;
        push(8'hFE, 8'h0B, 8'h0C, 8'h04, 8'h05, 1'b1, 1'b0); check("unaligned_wrap");
        tick();
        push(8'h02, 8'h06, 8'h00, 8'h04, 8'h01, 1'b1, 1'b0); check("unaligned_step");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
